// File: rtl/out_check_pkg.sv
// Shared types and helpers for the output-channel checker.
package out_check_pkg;

  // Checker phases: collecting expected words, checking the live stream, verdict held.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } out_check_state_t;

  // Default data word width shared with the processor harness.
  localparam int MemoryElementWidth = 12;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/out_check_mem.sv
// Expected-value store: one write port for loading, one combinational read port.
module out_check_mem #(
  parameter int Width     = 12,
  parameter int Depth     = 32,
  parameter int AddrWidth = 5
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);
  import out_check_pkg::*;

  logic [Width-1:0] mem_q [Depth];

  // Contents need no reset: nothing is read before the corresponding word is loaded.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read address is the running receive count, so the compare value is ready in the same cycle.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/out_check.sv
// Output-channel checker: loads an expected sequence, then compares the writer's stream against it.
module out_check #(
  parameter int MemoryElementWidth = out_check_pkg::MemoryElementWidth,
  parameter int NExpected          = 32,
  parameter int NOut               = 200
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       loadValid,
  input  logic [MemoryElementWidth-1:0]              loadData,
  input  logic                                       loadLast,
  input  logic                                       outValid,
  input  logic [MemoryElementWidth-1:0]              outData,
  output logic                                       outReady,
  input  logic                                       programDone,
  output logic                                       finished,
  output logic                                       success,
  output logic [out_check_pkg::cnt_width(NOut)-1:0]  received,
  output logic [out_check_pkg::cnt_width(NOut)-1:0]  mismatchIndex,
  output logic [MemoryElementWidth-1:0]              mismatchData
);
  import out_check_pkg::*;

  localparam int CW = cnt_width(NOut);
  localparam int EW = cnt_width(NExpected);
  localparam int AW = (NExpected > 1) ? $clog2(NExpected) : 1;
  localparam int XW = (CW > EW) ? CW : EW;

  out_check_state_t state_q, state_d;
  logic [EW-1:0] load_count_q, load_count_d;
  logic [EW-1:0] expected_count_q, expected_count_d;
  logic [CW-1:0] received_q, received_d;
  logic [CW-1:0] mismatch_index_q, mismatch_index_d;
  logic [MemoryElementWidth-1:0] mismatch_data_q, mismatch_data_d;
  logic error_q, error_d;
  logic overflow_q, overflow_d;
  logic mismatch_seen_q, mismatch_seen_d;
  logic out_ready_q, out_ready_d;
  logic finished_q, finished_d;
  logic success_q, success_d;

  logic                          mem_we;
  logic [AW-1:0]                 mem_waddr;
  logic [AW-1:0]                 mem_raddr;
  logic [MemoryElementWidth-1:0] mem_rdata;
  logic                          transfer;
  logic                          in_range;
  logic                          capture;

  out_check_mem #(
    .Width     (MemoryElementWidth),
    .Depth     (NExpected),
    .AddrWidth (AW)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (loadData),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Next-state logic: loading, per-word compare, first-mismatch capture and the final verdict.
  always_comb begin
    state_d          = state_q;
    load_count_d     = load_count_q;
    expected_count_d = expected_count_q;
    received_d       = received_q;
    mismatch_index_d = mismatch_index_q;
    mismatch_data_d  = mismatch_data_q;
    error_d          = error_q;
    overflow_d       = overflow_q;
    mismatch_seen_d  = mismatch_seen_q;
    mem_we           = 1'b0;
    mem_waddr        = AW'(load_count_q);
    // Only meaningful while in_range, which keeps the truncated index inside the store.
    mem_raddr        = AW'(received_q);
    in_range         = XW'(received_q) < XW'(expected_count_q);
    transfer         = 1'b0;
    capture          = 1'b0;

    case (state_q)
      LOAD: begin
        if (loadValid) begin
          mem_we       = 1'b1;
          load_count_d = load_count_q + EW'(1);
          // A full store starts checking even without an explicit last marker.
          if (loadLast || (load_count_q == EW'(NExpected - 1))) begin
            state_d          = RUN;
            expected_count_d = load_count_q + EW'(1);
          end
        end
      end
      RUN: begin
        transfer = outValid && out_ready_q;
        if (transfer) begin
          if (in_range) begin
            if (outData != mem_rdata) begin
              error_d = 1'b1;
              capture = 1'b1;
            end
          end else begin
            // Any word beyond the expected sequence is an error in itself.
            overflow_d = 1'b1;
            error_d    = 1'b1;
            capture    = 1'b1;
          end
          // Saturate rather than follow the writer's wrap of its output area.
          if (received_q != CW'(NOut)) begin
            received_d = received_q + CW'(1);
          end
        end
        // A word arriving alongside programDone is checked above before the verdict is taken.
        if (programDone) begin
          state_d = DONE;
        end
      end
      DONE: begin
      end
      default: state_d = LOAD;
    endcase

    if (capture && !mismatch_seen_q) begin
      mismatch_seen_d  = 1'b1;
      mismatch_index_d = received_q;
      mismatch_data_d  = outData;
    end

    out_ready_d = (state_d == RUN);
    finished_d  = (state_d == DONE);
    success_d   = (state_d == DONE) && !error_d &&
                  (XW'(received_d) == XW'(expected_count_d));
  end

  // State register with synchronous reset; all outputs come straight from these flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= LOAD;
      load_count_q     <= '0;
      expected_count_q <= '0;
      received_q       <= '0;
      mismatch_index_q <= '0;
      mismatch_data_q  <= '0;
      error_q          <= 1'b0;
      overflow_q       <= 1'b0;
      mismatch_seen_q  <= 1'b0;
      out_ready_q      <= 1'b0;
      finished_q       <= 1'b0;
      success_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      load_count_q     <= load_count_d;
      expected_count_q <= expected_count_d;
      received_q       <= received_d;
      mismatch_index_q <= mismatch_index_d;
      mismatch_data_q  <= mismatch_data_d;
      error_q          <= error_d;
      overflow_q       <= overflow_d;
      mismatch_seen_q  <= mismatch_seen_d;
      out_ready_q      <= out_ready_d;
      finished_q       <= finished_d;
      success_q        <= success_d;
    end
  end

  assign outReady      = out_ready_q;
  assign finished      = finished_q;
  assign success       = success_q;
  assign received      = received_q;
  assign mismatchIndex = mismatch_index_q;
  assign mismatchData  = mismatch_data_q;

endmodule

// File: tb/tb_out_check.sv
// Self-checking bench for out_check: table of stream scenarios plus hand-written corner sequences.
module tb_out_check;

  localparam int W  = 12;
  localparam int NE = 32;
  localparam int NO = 200;
  localparam int CW = $clog2(NO + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          loadValid;
  logic [W-1:0]  loadData;
  logic          loadLast;
  logic          outValid;
  logic [W-1:0]  outData;
  logic          outReady;
  logic          programDone;
  logic          finished;
  logic          success;
  logic [CW-1:0] received;
  logic [CW-1:0] mismatchIndex;
  logic [W-1:0]  mismatchData;

  out_check #(
    .MemoryElementWidth (W),
    .NExpected          (NE),
    .NOut               (NO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .loadValid     (loadValid),
    .loadData      (loadData),
    .loadLast      (loadLast),
    .outValid      (outValid),
    .outData       (outData),
    .outReady      (outReady),
    .programDone   (programDone),
    .finished      (finished),
    .success       (success),
    .received      (received),
    .mismatchIndex (mismatchIndex),
    .mismatchData  (mismatchData)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int ref_vals [25] = '{1, 3, 5, 9, 10, 2, 4, 5, 9, 10, 2, 4, 5, 9, 10,
                        2, 4, 6, 8, 10, 2, 4, 5, 7, 8};
  logic [W-1:0] load_buf [NE];
  int           load_n;

  typedef struct {
    string name;
    int    n_send;
    int    bad_idx;
    int    bad_val;
    bit    done_with_last;
    bit    exp_success;
    int    exp_received;
    int    exp_mm_index;
    int    exp_mm_data;
  } scen_t;

  scen_t scen [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    loadValid   = 1'b0;
    loadData    = '0;
    loadLast    = 1'b0;
    outValid    = 1'b0;
    outData     = '0;
    programDone = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " outReady"}, int'(outReady), 0);
    chk({tag, " finished"}, int'(finished), 0);
    chk({tag, " success"}, int'(success), 0);
    chk({tag, " received"}, int'(received), 0);
    chk({tag, " mismatchIndex"}, int'(mismatchIndex), 0);
    chk({tag, " mismatchData"}, int'(mismatchData), 0);
  endtask

  // Load load_buf[0..n-1]; outReady must stay low until the edge that stores the final word.
  task automatic load_words(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      loadValid = 1'b1;
      loadData  = load_buf[i];
      loadLast  = with_last && (i == n - 1);
      tick();
      if (i < n - 1) chk("outReady low during load", int'(outReady), 0);
    end
    loadValid = 1'b0;
    loadLast  = 1'b0;
    chk("outReady high after final load", int'(outReady), 1);
    load_n = n;
  endtask

  // Stream n words back-to-back; words past the loaded count carry 0xAB.
  task automatic stream(input int n, input int bad_idx, input int bad_val, input bit done_last);
    for (int i = 0; i < n; i++) begin
      outValid    = 1'b1;
      outData     = (i < load_n) ? load_buf[i] : W'(12'h0AB);
      if (i == bad_idx) outData = W'(bad_val);
      programDone = done_last && (i == n - 1);
      tick();
    end
    outValid    = 1'b0;
    programDone = 1'b0;
  endtask

  task automatic pulse_done();
    chk("finished low before programDone", int'(finished), 0);
    chk("success low before programDone", int'(success), 0);
    programDone = 1'b1;
    tick();
    programDone = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    scen[0] = '{"full_pass",       25, -1, 0, 1'b0, 1'b1, 25, 0,  0};
    scen[1] = '{"mismatch_17",     25, 17, 5, 1'b0, 1'b0, 25, 17, 5};
    scen[2] = '{"short_24",        24, -1, 0, 1'b0, 1'b0, 24, 0,  0};
    scen[3] = '{"long_26",         26, -1, 0, 1'b0, 1'b0, 26, 25, 171};
    scen[4] = '{"done_with_last",  25, -1, 0, 1'b1, 1'b1, 25, 0,  0};
    scen[5] = '{"mismatch_last",   25, 24, 9, 1'b0, 1'b0, 25, 24, 9};
    scen[6] = '{"mismatch_and_long", 26, 2, 7, 1'b0, 1'b0, 26, 2, 7};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_all_zero("reset");
    $display("reset: outputs cleared");

    // outValid held high in LOAD must not be accepted.
    outValid = 1'b1;
    outData  = 12'd1;
    for (int i = 0; i < 3; i++) tick();
    chk("load ignores outValid outReady", int'(outReady), 0);
    chk("load ignores outValid received", int'(received), 0);
    outValid = 1'b0;
    $display("load_ignores_out: received=%0d", received);

    for (int s = 0; s < 7; s++) begin
      do_reset();
      for (int i = 0; i < 25; i++) load_buf[i] = W'(ref_vals[i]);
      load_words(25, 1'b1);
      stream(scen[s].n_send, scen[s].bad_idx, scen[s].bad_val, scen[s].done_with_last);
      if (!scen[s].done_with_last) pulse_done();
      chk({scen[s].name, " finished"}, int'(finished), 1);
      chk({scen[s].name, " success"}, int'(success), int'(scen[s].exp_success));
      chk({scen[s].name, " received"}, int'(received), scen[s].exp_received);
      chk({scen[s].name, " mismatchIndex"}, int'(mismatchIndex), scen[s].exp_mm_index);
      chk({scen[s].name, " mismatchData"}, int'(mismatchData), scen[s].exp_mm_data);
      chk({scen[s].name, " outReady in DONE"}, int'(outReady), 0);
      // DONE is terminal: further traffic changes nothing.
      outValid    = 1'b1;
      outData     = 12'd3;
      programDone = 1'b1;
      tick();
      tick();
      idle_inputs();
      chk({scen[s].name, " received held"}, int'(received), scen[s].exp_received);
      chk({scen[s].name, " finished held"}, int'(finished), 1);
      $display("%s: finished=%0d success=%0d received=%0d mismatchIndex=%0d mismatchData=%0d",
               scen[s].name, finished, success, received, mismatchIndex, mismatchData);
    end

    // Filling the store without loadLast enters RUN on its own; loadValid in RUN is ignored.
    do_reset();
    for (int i = 0; i < NE; i++) load_buf[i] = W'(100 + 37 * i);
    load_words(NE, 1'b0);
    loadValid = 1'b1;
    loadData  = '0;
    stream(NE, -1, 0, 1'b0);
    loadValid = 1'b0;
    pulse_done();
    chk("auto_run success", int'(success), 1);
    chk("auto_run received", int'(received), NE);
    $display("auto_run: success=%0d received=%0d", success, received);

    // Reset mid-stream discards everything; a fresh short sequence then passes.
    do_reset();
    for (int i = 0; i < 25; i++) load_buf[i] = W'(ref_vals[i]);
    load_words(25, 1'b1);
    stream(10, -1, 0, 1'b0);
    chk("mid_stream received before reset", int'(received), 10);
    do_reset();
    chk_all_zero("mid_stream reset");
    load_buf[0] = 12'd7;
    load_buf[1] = 12'd8;
    load_buf[2] = 12'd9;
    load_words(3, 1'b1);
    stream(3, -1, 0, 1'b0);
    pulse_done();
    chk("after_reset finished", int'(finished), 1);
    chk("after_reset success", int'(success), 1);
    chk("after_reset received", int'(received), 3);
    $display("reset_mid_stream: success=%0d received=%0d", success, received);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_check.md
# out_check

Output-channel checker: the reading end of the processor's out channel. It receives each word the running program writes to its output channel and compares it in order against an expected sequence preloaded through a load port. It raises `finished`/`success` once the program signals completion. It sits beside the processor in the FPGA test harness and replaces the inline end-of-program comparison against output memory.

## Interface
Parameters:
- `MemoryElementWidth`, 12, width of every data word.
- `NExpected`, 32, capacity of the expected-value store.
- `NOut`, 200, size of the writer's output area; sets the receive-counter saturation limit.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `loadValid`  in  1  expected word present on `loadData`.
- `loadData`  in  MemoryElementWidth  expected word.
- `loadLast`  in  1  qualifies `loadValid`; marks the final expected word.
- `outValid`  in  1  writer presents an output word.
- `outData`  in  MemoryElementWidth  output word.
- `outReady`  out  1  checker accepts `outData` this cycle.
- `programDone`  in  1  writer has reached its end state; level or pulse.
- `finished`  out  1  checking complete; sticky.
- `success`  out  1  valid only while `finished`=1.
- `received`  out  $clog2(NOut+1)  words accepted so far; saturates at NOut.
- `mismatchIndex`  out  $clog2(NOut+1)  index of the first failing word.
- `mismatchData`  out  MemoryElementWidth  value received at `mismatchIndex`.

## Operation
- States: LOAD, RUN, DONE.
- Reset puts the block in LOAD. All outputs reset to 0, and the `loadCount`, `expectedCount`, `error`, `overflow` and `mismatchSeen` registers clear.
- LOAD state:
  - `outReady`=0. `outValid` and `programDone` are ignored.
  - Each `loadValid` writes `loadData` to `exp[loadCount]` and increments `loadCount`.
  - The state moves to RUN on the edge that stores a word with `loadLast`=1, or on the edge that stores word NExpected-1.
  - `expectedCount` is set to the number of words stored.
- RUN state:
  - `outReady`=1. A transfer occurs when `outValid` && `outReady`.
  - When `received` < `expectedCount`, the block compares `outData` with `exp[received]`.
  - On inequality, `error` is set. If `mismatchSeen`=0, `mismatchIndex`/`mismatchData` capture `received`/`outData` and `mismatchSeen` is set. Later mismatches never overwrite the capture.
  - When `received` >= `expectedCount`, `overflow` and `error` are set. If no mismatch has been captured yet, this transfer is captured as the first mismatch.
  - `received` increments per transfer and saturates at NOut. The writer's own wrap at NOut does not reset it.
  - When `programDone`=1, the state moves to DONE.
  - If `outValid` and `programDone` are both high in the same cycle, the word is accepted and checked first, then the state moves to DONE.
  - `loadValid` is ignored in RUN.
- DONE state:
  - `outReady`=0 and `finished`=1.
  - `success` = !`error` && (`received` == `expectedCount`). A short stream gives `success`=0.
  - The block stays in DONE until reset. Further `outValid`/`programDone` have no effect.
- Reset mid-operation, in any state, returns the block to LOAD and discards all expected data and counts.

## Timing
- `outReady` is a registered function of state. It is high from the cycle after the final load edge.
- Compare results, `received` and the mismatch capture update on the transfer edge and are visible in the next cycle.
- `finished` and `success` rise together, one cycle after `programDone` is sampled high in RUN.
- Minimum latency from the final load word to the first accepted output word is 1 cycle.
- Throughput is one word per cycle with no back-pressure bubbles in RUN.
- `success` is 0 whenever `finished`=0.

## Structure
- Package `out_check_pkg` holds:
  - the state enum `out_check_state_t` (LOAD, RUN, DONE);
  - `MemoryElementWidth` as the shared default;
  - the counter-width function.
- Sub-module `out_check_mem` holds the expected store:
  - NExpected × MemoryElementWidth register array;
  - one write port (load), one asynchronous read port indexed by `received`.
- The top level contains the FSM, counters, compare logic and sticky flags.

## Test plan
- Full pass:
  - Load the 25 values 1,3,5,9,10, 2,4,5,9,10, 2,4,5,9,10, 2,4,6,8,10, 2,4,5,7,8, with `loadLast` on the 25th.
  - Stream the same 25 values back-to-back, then pulse `programDone`.
  - Required: `finished`=1 and `success`=1 one cycle later, `received`=25.
- Single mismatch: same load, but word 17 is sent as 5 instead of 6. Required: `success`=0, `mismatchIndex`=17, `mismatchData`=5.
- Short and long streams:
  - Short: send 24 words, then `programDone`. Required: `success`=0, `received`=24.
  - Long: send 26 words. Required: `overflow`=1, `success`=0, `mismatchIndex`=25.
- Simultaneous events: the last word arrives with `programDone` in the same cycle. Required: the word is counted (`received`=25) and `success`=1.
- Load/stream boundaries:
  - `outValid` held high during LOAD is not accepted (`outReady`=0, `received`=0).
  - Loading NExpected words without `loadLast` auto-enters RUN.
- Reset mid-stream: reset after 10 words. Required: state LOAD, all outputs 0; a subsequent 3-word load and matching stream gives `success`=1.
